mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  in  1  operation offered.
REQ-005 SHALL have port in_ready  out  1  operation accepted when in_valid && in_ready.
REQ-006 SHALL have port in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have ports in_a, in_b  in  32 each  operands.
REQ-008 SHALL have port in_tag  in  TAG_W  tag carried to output.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1, out_data out 32, out_tag out TAG_W  result channel.
REQ-010 SHALL have port flush  in  1  discard in-flight operation.
REQ-011 SHALL have ports m_ai, m_bi  out  33 each  sign-extended operands to multiplier.
REQ-012 SHALL have ports m_req out 1, m_r in 64, m_rdy in 1, m_rst_n out 1  multiplier control.
REQ-013 SHALL have port busy  out  1  state != IDLE.

Function
REQ-014 FSM SHALL have states IDLE, CALC, RESP, ABORT.
REQ-015 in_ready SHALL be 1 only in IDLE with flush low.
REQ-016 On accept, SHALL register operands/op/tag and enter CALC.
REQ-017 Extension: MUL, MULH -> both signed; MULHSU -> a signed, b zero; MULHU -> both zero.
REQ-018 m_req SHALL be 1 in CALC and ABORT; m_ai/m_bi SHALL stay stable from accept until m_rdy sampled (multiplier applies result sign from live operands).
REQ-019 CALC + m_rdy: SHALL capture out_data = m_r[31:0] for MUL, else m_r[63:32], and enter RESP; m_req SHALL be 0 next cycle.
REQ-020 RESP: out_valid = 1, out_data/out_tag held until out_ready; then IDLE.
REQ-021 out_valid SHALL rise exactly one cycle after the cycle m_rdy is sampled high.
REQ-022 flush in IDLE: no accept, no effect. In CALC: enter ABORT. In RESP: drop out_valid, enter IDLE.
REQ-023 ABORT SHALL hold m_req and operands until m_rdy, discard the result, and return to IDLE with no out_valid.
REQ-024 m_rdy outside CALC/ABORT SHALL be ignored.
REQ-025 out_ready and flush simultaneous in RESP: flush wins; the result counts as not delivered.

Reset
REQ-026 rst SHALL immediately force IDLE, out_valid = 0, m_req = 0, busy = 0, and out_data/out_tag/m_ai/m_bi = 0.
REQ-027 m_rst_n SHALL equal !rst so the multiplier's synchronous counter clears during reset.
REQ-028 Reset mid-CALC SHALL drop the operation; no output after deassertion.

Configuration
REQ-029 Macro MUL_RESULT_CACHE_EN SHALL gate a last-product cache.
REQ-030 With it: store {m_ai, m_bi, m_r} on each completed CALC; an accept whose extended operands match a valid entry SHALL skip CALC, go to RESP next cycle with the cached product, and keep m_req low.
REQ-031 The cache SHALL be invalidated by rst, flush, and ABORT completion.
REQ-032 Without it: every operation SHALL go through CALC; no cache registers.

Structure
REQ-033 Package mul_pkg SHALL hold the op enum, FSM state enum, and the op-to-extension function.
REQ-034 Cache SHALL be sub-module mul_result_cache, instantiated only under the macro; the multiplier is instantiated by the parent.

Verification
REQ-035 MULH a=0xFFFFFFFF, b=0x00000002 -> out_data 0xFFFFFFFF; with the team multiplier, out_valid 5 cycles after accept.
REQ-036 MULHU a=0xFFFFFFFF, b=0x00000002 -> out_data 0x00000001; MUL same operands -> out_data 0xFFFFFFFE.
REQ-037 MULHSU a=0x80000000, b=0xFFFFFFFF -> out_data 0x80000000; out_ready low 3 cycles -> data/tag held.
REQ-038 flush 2 cycles after accept -> no out_valid; m_req held until m_rdy; the next MUL 3*4 -> 12.
REQ-039 rst asserted mid-CALC -> out_valid/m_req 0 at once; a following op completes correctly.
REQ-040 MUL_RESULT_CACHE_EN: MULH 7,9 then MUL 7,9 -> second result 63, out_valid 1 cycle after accept, m_req never asserted.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the sequential multiplier controller.
//   mul_op_e    : RISC-V style multiply opcode (in_op encoding)
//   mul_state_e : controller FSM state (also exported on dbg_state)
//   op_ext_sgn  : per-operand sign-extension selection for an opcode
//   ext33       : widen a 32-bit operand to the 33-bit multiplier operand
//   pick_word   : select the result word of the 64-bit product for an opcode
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int OPW   = XLEN + 1;
  localparam int PRODW = 2 * XLEN;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    RESP  = 2'b10,
    ABORT = 2'b11
  } mul_state_e;

  // Returns {a_signed, b_signed}.
  function automatic logic [1:0] op_ext_sgn(input mul_op_e op);
    case (op)
      OP_MUL, OP_MULH: return 2'b11;
      OP_MULHSU:       return 2'b10;
      default:         return 2'b00;
    endcase
  endfunction

  function automatic logic [OPW-1:0] ext33(input logic [XLEN-1:0] v, input logic sgn);
    return {sgn & v[XLEN-1], v};
  endfunction

  function automatic logic [XLEN-1:0] pick_word(input mul_op_e op, input logic [PRODW-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PRODW-1:XLEN];
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// mul_result_cache: single-entry last-product cache keyed on the extended
// multiplier operands. Only instantiated when MUL_RESULT_CACHE_EN is defined.
//   clk, rst         : clock, asynchronous active-high reset (invalidates)
//   clr_i            : invalidate the entry
//   wr_i             : store {wr_ai_i, wr_bi_i, wr_r_i} and mark valid
//   lk_ai_i, lk_bi_i : lookup key (extended operands of the offered op)
//   hit_o, r_o       : entry valid and key matches; cached 64-bit product
module mul_result_cache
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [OPW-1:0]   wr_ai_i,
  input  logic [OPW-1:0]   wr_bi_i,
  input  logic [PRODW-1:0] wr_r_i,
  input  logic [OPW-1:0]   lk_ai_i,
  input  logic [OPW-1:0]   lk_bi_i,
  output logic             hit_o,
  output logic [PRODW-1:0] r_o
);

  logic             valid_q;
  logic [OPW-1:0]   ai_q;
  logic [OPW-1:0]   bi_q;
  logic [PRODW-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ai_q    <= '0;
      bi_q    <= '0;
      r_q     <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      ai_q    <= wr_ai_i;
      bi_q    <= wr_bi_i;
      r_q     <= wr_r_i;
    end
  end

  assign hit_o = valid_q && (ai_q == lk_ai_i) && (bi_q == lk_bi_i);
  assign r_o   = r_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: controller sequencing one multiply at a time through an
// external multi-cycle 33x33 signed multiplier.
// Optional feature: define MUL_RESULT_CACHE_EN to add a last-product cache that
// lets an operation with identical extended operands skip the multiplier.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : operation request handshake
//   in_op, in_a, in_b, in_tag    : opcode, operands, destination tag
//   out_valid/out_ready          : result handshake; out_data, out_tag
//   flush                        : discard the in-flight operation
//   m_ai, m_bi                   : extended operands to the multiplier
//   m_req, m_r, m_rdy, m_rst_n   : multiplier request, product, done, reset
//   busy                         : controller not idle
//   dbg_state                    : current FSM state (mul_state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid && ready; once
// out_valid is raised, out_data/out_tag stay stable until that transfer (or a
// flush, which withdraws the result).
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic [32:0]      m_ai,
  output logic [32:0]      m_bi,
  output logic             m_req,
  input  logic [63:0]      m_r,
  input  logic             m_rdy,
  output logic             m_rst_n,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  mul_state_e       state_q, state_d;
  logic [OPW-1:0]   ai_q, bi_q;
  mul_op_e          op_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  data_q;

  mul_op_e          in_op_e;
  logic [1:0]       sgn;
  logic [OPW-1:0]   ext_a, ext_b;
  logic             accept;
  logic             calc_done;
  logic             abort_done;
  logic             hit;
  logic [PRODW-1:0] hit_r;

  always_comb begin
    in_op_e = mul_op_e'(in_op);
    sgn     = op_ext_sgn(in_op_e);
    ext_a   = ext33(in_a, sgn[1]);
    ext_b   = ext33(in_b, sgn[0]);
  end

  assign accept     = in_valid && in_ready;
  assign calc_done  = (state_q == CALC) && m_rdy && !flush;
  assign abort_done = (state_q == ABORT) && m_rdy;

`ifdef MUL_RESULT_CACHE_EN
  mul_result_cache u_cache (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush || abort_done),
    .wr_i    (calc_done),
    .wr_ai_i (ai_q),
    .wr_bi_i (bi_q),
    .wr_r_i  (m_r),
    .lk_ai_i (ext_a),
    .lk_bi_i (ext_b),
    .hit_o   (hit),
    .r_o     (hit_r)
  );
`else
  assign hit   = 1'b0;
  assign hit_r = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = hit ? RESP : CALC;
      CALC: begin
        // flush coinciding with m_rdy: the multiplier handshake is already
        // complete, so there is nothing left to drain -- go straight home.
        if (m_rdy)      state_d = flush ? IDLE : RESP;
        else if (flush) state_d = ABORT;
      end
      RESP:  if (flush || out_ready) state_d = IDLE;
      ABORT: if (m_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE) && !flush;
    out_valid = (state_q == RESP);
    m_req     = (state_q == CALC) || (state_q == ABORT);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

  // Operand/result registers. Operands are only loaded on accept, so they stay
  // stable through CALC/ABORT as the multiplier requires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai_q   <= '0;
      bi_q   <= '0;
      op_q   <= OP_MUL;
      tag_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      ai_q  <= ext_a;
      bi_q  <= ext_b;
      op_q  <= in_op_e;
      tag_q <= in_tag;
      if (hit) data_q <= pick_word(in_op_e, hit_r);
    end else if (calc_done) begin
      data_q <= pick_word(op_q, m_r);
    end
  end

  assign m_ai     = ai_q;
  assign m_bi     = bi_q;
  assign out_data = data_q;
  assign out_tag  = tag_q;
  assign m_rst_n  = !rst;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             flush;
  logic [32:0]      m_ai, m_bi;
  logic             m_req;
  logic [63:0]      m_r;
  logic             m_rdy;
  logic             m_rst_n;
  logic             busy;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  mul_seq_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .flush(flush),
    .m_ai(m_ai), .m_bi(m_bi),
    .m_req(m_req), .m_r(m_r), .m_rdy(m_rdy), .m_rst_n(m_rst_n),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- team multiplier model ----------------
  // Four request cycles per product; counter clears synchronously on m_rst_n.
  logic [2:0]         mcnt;
  logic signed [65:0] mprod;
  always_ff @(posedge clk) begin
    if (!m_rst_n || !m_req || m_rdy) mcnt <= 3'd0;
    else                             mcnt <= mcnt + 3'd1;
  end
  assign m_rdy = m_req && (mcnt == 3'd3);
  assign mprod = $signed(m_ai) * $signed(m_bi);
  assign m_r   = mprod[63:0];

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] uu;
    longint      ss, su;
    uu = {32'b0, a} * {32'b0, b};
    ss = longint'($signed(a)) * longint'($signed(b));
    su = longint'($signed(a)) * longint'({32'b0, b});
    case (op)
      2'b00:   return uu[31:0];
      2'b01:   return ss[63:32];
      2'b10:   return su[63:32];
      default: return uu[63:32];
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected data=%h tag=%h", out_data, out_tag);
      end else begin
        logic [31:0]      e;
        logic [TAG_W-1:0] t;
        e = exp_q.pop_front();
        t = exp_tag_q.pop_front();
        checks++;
        if (out_data !== e) begin errors++; $display("FAIL sb_data got=%h exp=%h", out_data, e); end
        checks++;
        if (out_tag !== t) begin errors++; $display("FAIL sb_tag got=%h exp=%h", out_tag, t); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at accept edge +#1.
  task automatic do_accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input bit push);
    bit ok = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout got=0 exp=1"); end
    else if (push) begin exp_q.push_back(model(op, a, b)); exp_tag_q.push_back(tag); end
  endtask

  // Cycles from the accept cycle to the first cycle with out_valid (-1 on timeout).
  task automatic wait_out_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_timeout busy=%b exp=0", busy); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req got=%b exp=0", m_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (m_rst_n !== 1'b0) begin errors++; $display("FAIL rst_m_rst_n got=%b exp=0", m_rst_n); end
    checks++; if ({out_data, out_tag, m_ai, m_bi} !== '0) begin
      errors++; $display("FAIL rst_regs data=%h tag=%h ai=%h bi=%h exp=0", out_data, out_tag, m_ai, m_bi);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (m_rst_n !== 1'b1) begin errors++; $display("FAIL rst_release_m_rst_n got=%b exp=1", m_rst_n); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_mulh();
    int lat;
    do_accept(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 1);
    checks++; if (m_ai !== 33'h1_FFFF_FFFF || m_bi !== 33'h0_0000_0002) begin
      errors++; $display("FAIL mulh_ext ai=%h bi=%h exp=1ffffffff/000000002", m_ai, m_bi);
    end
    checks++; if (m_req !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mulh_calc m_req=%b in_ready=%b exp=1/0", m_req, in_ready);
    end
    wait_out_valid(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL mulh_latency got=%0d exp=5", lat); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL resp_m_req got=%b exp=0", m_req); end
    wait_idle();
  endtask

  task automatic test_mulhu_mul();
    do_accept(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 1);
    checks++; if (m_ai !== 33'h0_FFFF_FFFF) begin errors++; $display("FAIL mulhu_ext ai=%h exp=0ffffffff", m_ai); end
    wait_idle();
    do_accept(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 1);
    wait_idle();
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    do_accept(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1);
    checks++; if (m_bi !== 33'h0_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_ext bi=%h exp=0ffffffff", m_bi); end
    wait_out_valid(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL hold_latency got=%0d exp=5", lat); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h8000_0000 || out_tag !== 5'd9) begin
        errors++; $display("FAIL hold_stall v=%b data=%h tag=%h exp=1/80000000/09", out_valid, out_data, out_tag);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_flush_calc();
    bit bad_req = 0, bad_op = 0, saw_valid = 0;
    do_accept(2'b00, 32'd5, 32'd6, 5'd1, 0);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (dbg_state !== 2'b11) begin errors++; $display("FAIL flush_abort_state got=%0d exp=3", dbg_state); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
      if (busy && !m_req) bad_req = 1;
      if (busy && (m_ai !== 33'd5 || m_bi !== 33'd6)) bad_op = 1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL flush_out_valid got=1 exp=0"); end
    checks++; if (bad_req) begin errors++; $display("FAIL abort_m_req got=0 exp=1"); end
    checks++; if (bad_op) begin errors++; $display("FAIL abort_operands ai=%h exp=5", m_ai); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b exp=0", busy); end
    @(posedge clk); #1;
    do_accept(2'b00, 32'd3, 32'd4, 5'd12, 1);
    wait_idle();
  endtask

  task automatic test_flush_resp();
    int lat;
    out_ready = 1'b0;
    do_accept(2'b00, 32'd10, 32'd11, 5'd7, 0);
    wait_out_valid(lat);
    @(posedge clk); #1; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_resp v=%b busy=%b exp=0/0", out_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int  lat;
    bit  saw_valid = 0;
    do_accept(2'b00, 32'd100, 32'd200, 5'd2, 0);
    @(posedge clk); #1; rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || m_req !== 1'b0 || busy !== 1'b0 || m_ai !== '0) begin
      errors++; $display("FAIL rst_mid v=%b req=%b busy=%b ai=%h exp=0", out_valid, m_req, busy, m_ai);
    end
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid || m_req) saw_valid = 1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL rst_mid_residue got=1 exp=0"); end
    @(posedge clk); #1;
    do_accept(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30, 1);
    wait_out_valid(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL rst_mid_latency got=%0d exp=5", lat); end
    wait_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [1:0]       op;
      logic [31:0]      a, b;
      logic [TAG_W-1:0] t;
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = (n == 0) ? 32'd0 : $urandom();
      t  = TAG_W'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 1) == 1);
      do_accept(op, a, b, t, 1);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1; out_ready = 1'b1;
      wait_idle();
    end
  endtask

`ifdef MUL_RESULT_CACHE_EN
  task automatic test_cache();
    int lat;
    bit saw_req = 0;
    do_accept(2'b01, 32'd7, 32'd9, 5'd20, 1);
    wait_idle();
    do_accept(2'b00, 32'd7, 32'd9, 5'd21, 1);
    if (m_req) saw_req = 1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m_req) saw_req = 1;
      if (out_valid && lat < 0) lat = k;
    end
    checks++; if (lat != 1) begin errors++; $display("FAIL cache_latency got=%0d exp=1", lat); end
    checks++; if (saw_req) begin errors++; $display("FAIL cache_m_req got=1 exp=0"); end
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    do_accept(2'b00, 32'd7, 32'd9, 5'd22, 1);
    wait_out_valid(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL cache_flush_inval got=%0d exp=5", lat); end
    wait_idle();
  endtask
`endif

  // ---------------- main sequence + report ----------------
  initial begin
    test_reset();
    test_mulh();
    test_mulhu_mul();
    test_hold();
    test_flush_calc();
    test_flush_resp();
    test_reset_mid();
    test_random();
`ifdef MUL_RESULT_CACHE_EN
    test_cache();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
